// File: rtl/frame_mode_ctrl.sv
// Frame-synchronous mode controller for the pixel output path.
// Configuration writes are held until the next frame start, the new mode is
// applied on that VSYNC edge, and the output is blanked for DRAIN_CYC cycles
// so that pixels still in flight under the old mode never reach the output.
// Frame and line counters run alongside from the same sync edge detectors.
module frame_mode_ctrl #(
  parameter int unsigned DRAIN_CYC = 8,
  parameter int unsigned FCNT_W    = 16
) (
  input  logic              clk_sys,
  input  logic              reset_sys,
  input  logic              CFG_VALID,
  input  logic [7:0]        CFG_REG,
  input  logic              InVSYNC,
  input  logic              InHSYNC,
  output logic [1:0]        mode_sel,
  output logic              out_blank,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              pending,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [11:0]       line_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [7:0]        DRAIN_LOAD = 8'(DRAIN_CYC);
  localparam logic [FCNT_W-1:0] FRAME_ONE  = {{(FCNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [1:0]        pendMode_q, pendMode_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        drainCnt_q, drainCnt_d;
  logic              drainCfg_q, drainCfg_d;
  logic              vsPrev_q, hsPrev_q;
  logic              armed_q;
  logic              ack_q, err_q;
  logic [FCNT_W-1:0] frame_q, frame_d;
  logic [11:0]       line_q, line_d;

  logic       vsEdge, hsEdge;
  logic       cfgIllegal;
  logic [1:0] cfgMode;
  logic       unusedCfg;

  // The armed flag masks the first cycle after reset, so a sync line already
  // high when reset releases is not mistaken for a fresh rising edge.
  assign vsEdge     = armed_q & InVSYNC & ~vsPrev_q;
  assign hsEdge     = armed_q & InHSYNC & ~hsPrev_q;
  assign cfgIllegal = (CFG_REG[1:0] == 2'b11);
  assign cfgMode    = cfgIllegal ? 2'b00 : CFG_REG[1:0];
  assign unusedCfg  = ^CFG_REG[7:2];

  // Mode FSM: latch requests, switch on frame start, then count out the drain.
  always_comb begin
    state_d    = state_q;
    pendMode_d = pendMode_q;
    mode_d     = mode_q;
    drainCnt_d = drainCnt_q;
    drainCfg_d = drainCfg_q;
    case (state_q)
      IDLE: begin
        if (CFG_VALID) begin
          pendMode_d = cfgMode;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (vsEdge) begin
          mode_d     = pendMode_q;
          drainCnt_d = DRAIN_LOAD;
          state_d    = DRAIN;
          drainCfg_d = CFG_VALID;
          if (CFG_VALID) begin
            pendMode_d = cfgMode;
          end
        end else if (CFG_VALID) begin
          pendMode_d = cfgMode;
        end
      end
      DRAIN: begin
        if (CFG_VALID) begin
          pendMode_d = cfgMode;
          drainCfg_d = 1'b1;
        end
        if (drainCnt_q <= 8'd1) begin
          drainCnt_d = 8'd0;
          drainCfg_d = 1'b0;
          state_d    = (drainCfg_q | CFG_VALID) ? PEND : IDLE;
        end else begin
          drainCnt_d = drainCnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame counter wraps freely; line counter restarts each frame and saturates.
  always_comb begin
    frame_d = frame_q;
    line_d  = line_q;
    if (vsEdge) begin
      frame_d = frame_q + FRAME_ONE;
      line_d  = hsEdge ? 12'd1 : 12'd0;
    end else if (hsEdge && (line_q != 12'hFFF)) begin
      line_d = line_q + 12'd1;
    end
  end

  // All state registers, cleared together by the synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      state_q    <= IDLE;
      pendMode_q <= 2'b00;
      mode_q     <= 2'b00;
      drainCnt_q <= 8'd0;
      drainCfg_q <= 1'b0;
      vsPrev_q   <= 1'b0;
      hsPrev_q   <= 1'b0;
      armed_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      frame_q    <= '0;
      line_q     <= 12'd0;
    end else begin
      state_q    <= state_d;
      pendMode_q <= pendMode_d;
      mode_q     <= mode_d;
      drainCnt_q <= drainCnt_d;
      drainCfg_q <= drainCfg_d;
      vsPrev_q   <= InVSYNC;
      hsPrev_q   <= InHSYNC;
      armed_q    <= 1'b1;
      ack_q      <= CFG_VALID;
      err_q      <= CFG_VALID & cfgIllegal;
      frame_q    <= frame_d;
      line_q     <= line_d;
    end
  end

  assign mode_sel  = mode_q;
  assign out_blank = (state_q == DRAIN);
  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;
  assign pending   = (state_q == PEND) | ((state_q == DRAIN) & drainCfg_q);
  assign frame_cnt = frame_q;
  assign line_cnt  = line_q;

endmodule

// File: tb/tb_frame_mode_ctrl.sv
// Directed testbench for frame_mode_ctrl (DRAIN_CYC=8, FCNT_W=4).
module tb_frame_mode_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_sys;
  logic        CFG_VALID;
  logic [7:0]  CFG_REG;
  logic        InVSYNC;
  logic        InHSYNC;
  logic [1:0]  mode_sel;
  logic        out_blank;
  logic        cfg_ack;
  logic        cfg_err;
  logic        pending;
  logic [3:0]  frame_cnt;
  logic [11:0] line_cnt;

  int total = 0;
  int bad   = 0;

  // Free-running 100 MHz system clock.
  always #5 clk_sys = ~clk_sys;

  frame_mode_ctrl #(.DRAIN_CYC(8), .FCNT_W(4)) dut (
    .clk_sys   (clk_sys),
    .reset_sys (reset_sys),
    .CFG_VALID (CFG_VALID),
    .CFG_REG   (CFG_REG),
    .InVSYNC   (InVSYNC),
    .InHSYNC   (InHSYNC),
    .mode_sel  (mode_sel),
    .out_blank (out_blank),
    .cfg_ack   (cfg_ack),
    .cfg_err   (cfg_err),
    .pending   (pending),
    .frame_cnt (frame_cnt),
    .line_cnt  (line_cnt)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One-cycle VSYNC pulse; returns at the sample right after the detected edge.
  task automatic vsyncEdge();
    InVSYNC = 1'b1;
    step();
    InVSYNC = 1'b0;
  endtask

  // One-cycle HSYNC pulse followed by a low cycle.
  task automatic hsyncPulse();
    InHSYNC = 1'b1;
    step();
    InHSYNC = 1'b0;
    step();
  endtask

  // Single-cycle configuration write.
  task automatic writeCfg(input logic [7:0] value);
    CFG_VALID = 1'b1;
    CFG_REG   = value;
    step();
    CFG_VALID = 1'b0;
  endtask

  // Counts consecutive blanked samples starting at the current one (bounded).
  task automatic countBlank(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!out_blank) break;
      n++;
      step();
    end
  endtask

  task automatic applyReset();
    reset_sys = 1'b1;
    CFG_VALID = 1'b0;
    CFG_REG   = 8'h00;
    InVSYNC   = 1'b0;
    InHSYNC   = 1'b0;
    step();
    step();
    reset_sys = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_sys = 1'b1;
    CFG_VALID = 1'b1;
    CFG_REG   = 8'h03;
    InVSYNC   = 1'b1;
    InHSYNC   = 1'b1;
    step();
    step();
    total++; if (mode_sel !== 2'd0) begin bad++; $display("[TB] FAIL reset_mode: got %0d expected 0", mode_sel); end
    total++; if (out_blank !== 1'b0) begin bad++; $display("[TB] FAIL reset_blank: got %0b expected 0", out_blank); end
    total++; if (cfg_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %0b expected 0", cfg_ack); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %0b expected 0", cfg_err); end
    total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending: got %0b expected 0", pending); end
    total++; if (frame_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_frame: got %0d expected 0", frame_cnt); end
    total++; if (line_cnt !== 12'd0) begin bad++; $display("[TB] FAIL reset_line: got %0d expected 0", line_cnt); end
    CFG_VALID = 1'b0;
    InHSYNC   = 1'b0;
    reset_sys = 1'b0;
    step();
    step();
    step();
    total++; if (frame_cnt !== 4'd0) begin bad++; $display("[TB] FAIL vsync_held_frame: got %0d expected 0", frame_cnt); end
    total++; if (out_blank !== 1'b0) begin bad++; $display("[TB] FAIL vsync_held_blank: got %0b expected 0", out_blank); end
    InVSYNC = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int n;
    applyReset();
    CFG_VALID = 1'b1;
    CFG_REG   = 8'h01;
    step();
    total++; if (cfg_ack !== 1'b1) begin bad++; $display("[TB] FAIL basic_ack: got %0b expected 1", cfg_ack); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL basic_err: got %0b expected 0", cfg_err); end
    total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL basic_pend1: got %0b expected 1", pending); end
    CFG_VALID = 1'b0;
    step();
    total++; if (cfg_ack !== 1'b0) begin bad++; $display("[TB] FAIL basic_ack_once: got %0b expected 0", cfg_ack); end
    total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL basic_pend2: got %0b expected 1", pending); end
    total++; if (mode_sel !== 2'd0) begin bad++; $display("[TB] FAIL basic_mode_early: got %0d expected 0", mode_sel); end
    vsyncEdge();
    total++; if (mode_sel !== 2'd1) begin bad++; $display("[TB] FAIL basic_mode: got %0d expected 1", mode_sel); end
    total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL basic_pend_clr: got %0b expected 0", pending); end
    total++; if (frame_cnt !== 4'd1) begin bad++; $display("[TB] FAIL basic_frame: got %0d expected 1", frame_cnt); end
    countBlank(n);
    total++; if (n != 8) begin bad++; $display("[TB] FAIL basic_drain_len: got %0d expected 8", n); end
    total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL basic_pend_end: got %0b expected 0", pending); end
  endtask

  task automatic test_last_write();
    int n;
    applyReset();
    writeCfg(8'h02);
    writeCfg(8'h01);
    step();
    vsyncEdge();
    total++; if (mode_sel !== 2'd1) begin bad++; $display("[TB] FAIL lastw_mode: got %0d expected 1", mode_sel); end
    countBlank(n);
    total++; if (n != 8) begin bad++; $display("[TB] FAIL lastw_drain_len: got %0d expected 8", n); end
    step();
    vsyncEdge();
    total++; if (out_blank !== 1'b0) begin bad++; $display("[TB] FAIL lastw_second_drain: got %0b expected 0", out_blank); end
    total++; if (mode_sel !== 2'd1) begin bad++; $display("[TB] FAIL lastw_mode_hold: got %0d expected 1", mode_sel); end
    total++; if (frame_cnt !== 4'd2) begin bad++; $display("[TB] FAIL lastw_frame: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_illegal();
    int n;
    applyReset();
    writeCfg(8'h02);
    vsyncEdge();
    countBlank(n);
    CFG_VALID = 1'b1;
    CFG_REG   = 8'hFF;
    step();
    total++; if (cfg_ack !== 1'b1) begin bad++; $display("[TB] FAIL illegal_ack: got %0b expected 1", cfg_ack); end
    total++; if (cfg_err !== 1'b1) begin bad++; $display("[TB] FAIL illegal_err: got %0b expected 1", cfg_err); end
    CFG_VALID = 1'b0;
    step();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL illegal_err_once: got %0b expected 0", cfg_err); end
    total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL illegal_pending: got %0b expected 1", pending); end
    vsyncEdge();
    total++; if (mode_sel !== 2'd0) begin bad++; $display("[TB] FAIL illegal_mode: got %0d expected 0", mode_sel); end
    countBlank(n);
    total++; if (n != 8) begin bad++; $display("[TB] FAIL illegal_drain_len: got %0d expected 8", n); end
  endtask

  task automatic test_drain_cfg();
    int n;
    applyReset();
    writeCfg(8'h01);
    vsyncEdge();
    step();
    step();
    writeCfg(8'h02);
    total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL dcfg_pending: got %0b expected 1", pending); end
    total++; if (mode_sel !== 2'd1) begin bad++; $display("[TB] FAIL dcfg_mode_drain: got %0d expected 1", mode_sel); end
    total++; if (cfg_ack !== 1'b1) begin bad++; $display("[TB] FAIL dcfg_ack: got %0b expected 1", cfg_ack); end
    vsyncEdge();
    total++; if (mode_sel !== 2'd1) begin bad++; $display("[TB] FAIL dcfg_vs_in_drain: got %0d expected 1", mode_sel); end
    countBlank(n);
    total++; if (n != 4) begin bad++; $display("[TB] FAIL dcfg_rest_len: got %0d expected 4", n); end
    step();
    step();
    total++; if (mode_sel !== 2'd1) begin bad++; $display("[TB] FAIL dcfg_mode_wait: got %0d expected 1", mode_sel); end
    total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL dcfg_pend_wait: got %0b expected 1", pending); end
    total++; if (out_blank !== 1'b0) begin bad++; $display("[TB] FAIL dcfg_blank_wait: got %0b expected 0", out_blank); end
    vsyncEdge();
    total++; if (mode_sel !== 2'd2) begin bad++; $display("[TB] FAIL dcfg_mode_new: got %0d expected 2", mode_sel); end
    total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL dcfg_pend_clr: got %0b expected 0", pending); end
    countBlank(n);
    total++; if (n != 8) begin bad++; $display("[TB] FAIL dcfg_drain_len: got %0d expected 8", n); end
    writeCfg(8'h02);
    vsyncEdge();
    total++; if (mode_sel !== 2'd2) begin bad++; $display("[TB] FAIL same_mode: got %0d expected 2", mode_sel); end
    countBlank(n);
    total++; if (n != 8) begin bad++; $display("[TB] FAIL same_drain_len: got %0d expected 8", n); end
  endtask

  task automatic test_coincident();
    int n;
    applyReset();
    writeCfg(8'h01);
    step();
    CFG_VALID = 1'b1;
    CFG_REG   = 8'h02;
    InVSYNC   = 1'b1;
    step();
    CFG_VALID = 1'b0;
    InVSYNC   = 1'b0;
    total++; if (mode_sel !== 2'd1) begin bad++; $display("[TB] FAIL coin_mode_old: got %0d expected 1", mode_sel); end
    total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL coin_pending: got %0b expected 1", pending); end
    total++; if (out_blank !== 1'b1) begin bad++; $display("[TB] FAIL coin_blank: got %0b expected 1", out_blank); end
    countBlank(n);
    total++; if (n != 8) begin bad++; $display("[TB] FAIL coin_drain_len: got %0d expected 8", n); end
    total++; if (pending !== 1'b1) begin bad++; $display("[TB] FAIL coin_pend_after: got %0b expected 1", pending); end
    vsyncEdge();
    total++; if (mode_sel !== 2'd2) begin bad++; $display("[TB] FAIL coin_mode_new: got %0d expected 2", mode_sel); end
  endtask

  task automatic test_counters();
    applyReset();
    for (int i = 0; i < 15; i++) begin
      vsyncEdge();
      step();
    end
    total++; if (frame_cnt !== 4'd15) begin bad++; $display("[TB] FAIL frame_15: got %0d expected 15", frame_cnt); end
    vsyncEdge();
    step();
    total++; if (frame_cnt !== 4'd0) begin bad++; $display("[TB] FAIL frame_wrap: got %0d expected 0", frame_cnt); end
    vsyncEdge();
    step();
    total++; if (frame_cnt !== 4'd1) begin bad++; $display("[TB] FAIL frame_17: got %0d expected 1", frame_cnt); end
    total++; if (line_cnt !== 12'd0) begin bad++; $display("[TB] FAIL line_clear: got %0d expected 0", line_cnt); end
    for (int i = 0; i < 3; i++) hsyncPulse();
    total++; if (line_cnt !== 12'd3) begin bad++; $display("[TB] FAIL line_3: got %0d expected 3", line_cnt); end
    InVSYNC = 1'b1;
    InHSYNC = 1'b1;
    step();
    InVSYNC = 1'b0;
    InHSYNC = 1'b0;
    step();
    total++; if (line_cnt !== 12'd1) begin bad++; $display("[TB] FAIL line_coincide: got %0d expected 1", line_cnt); end
    vsyncEdge();
    step();
    for (int i = 0; i < 5000; i++) hsyncPulse();
    total++; if (line_cnt !== 12'd4095) begin bad++; $display("[TB] FAIL line_saturate: got %0d expected 4095", line_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    applyReset();
    writeCfg(8'h02);
    vsyncEdge();
    step();
    writeCfg(8'h01);
    reset_sys = 1'b1;
    step();
    total++; if (mode_sel !== 2'd0) begin bad++; $display("[TB] FAIL rmd_mode: got %0d expected 0", mode_sel); end
    total++; if (out_blank !== 1'b0) begin bad++; $display("[TB] FAIL rmd_blank: got %0b expected 0", out_blank); end
    total++; if (cfg_ack !== 1'b0) begin bad++; $display("[TB] FAIL rmd_ack: got %0b expected 0", cfg_ack); end
    total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL rmd_pending: got %0b expected 0", pending); end
    total++; if (frame_cnt !== 4'd0) begin bad++; $display("[TB] FAIL rmd_frame: got %0d expected 0", frame_cnt); end
    reset_sys = 1'b0;
    step();
    step();
    vsyncEdge();
    total++; if (out_blank !== 1'b0) begin bad++; $display("[TB] FAIL rmd_no_drain: got %0b expected 0", out_blank); end
    total++; if (mode_sel !== 2'd0) begin bad++; $display("[TB] FAIL rmd_mode_after: got %0d expected 0", mode_sel); end
    total++; if (frame_cnt !== 4'd1) begin bad++; $display("[TB] FAIL rmd_frame_after: got %0d expected 1", frame_cnt); end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    reset_sys = 1'b1;
    CFG_VALID = 1'b0;
    CFG_REG   = 8'h00;
    InVSYNC   = 1'b0;
    InHSYNC   = 1'b0;
    test_reset();
    test_basic();
    test_last_write();
    test_illegal();
    test_drain_cfg();
    test_coincident();
    test_counters();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
